// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, parity modes, parameter legality
// check and the parity helper used by the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic bit cfg_ok(input int clks, input int dbits, input int par, input int stops);
        return (clks >= 2) && (dbits >= 5) && (dbits <= 9) &&
               (par >= PAR_NONE) && (par <= PAR_ODD) && ((stops == 1) || (stops == 2));
    endfunction

    // Zero-extended data bits do not disturb the reduction, so one width serves all sizes.
    function automatic logic parity_bit(input logic [8:0] data, input int par);
        if (par == PAR_ODD) begin
            return ~^data;
        end else begin
            return ^data;
        end
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last cycle of
// each bit. Shared between the TX and RX sides.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

    // Next count: restart at every bit boundary or while held clear.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity, one or two stop bits. Outputs other than tx_ready are registered.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_dv,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_active,
    output logic                 tx_done
);

    if (!cfg_ok(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS)) begin : g_bad_cfg
        $error("uart_tx_cfg: illegal parameter combination");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 ser_q, ser_d;
    logic                 act_q, act_d;
    logic                 done_q, done_d;
    logic                 tick;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == ST_IDLE),
        .tick  (tick)
    );

    assign tx_ready  = (state_q == ST_IDLE);
    assign tx_serial = ser_q;
    assign tx_active = act_q;
    assign tx_done   = done_q;

    // Next-state and next-output logic; data is shifted so bit 0 is always the next to send.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        ser_d      = ser_q;
        act_d      = act_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ser_d = 1'b1;
                act_d = 1'b0;
                if (tx_dv) begin
                    state_d    = ST_START;
                    data_d     = tx_data;
                    par_d      = parity_bit(9'(tx_data), PARITY);
                    bit_cnt_d  = 4'd0;
                    stop_cnt_d = 1'b0;
                    ser_d      = 1'b0;
                    act_d      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    ser_d   = data_q[0];
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    state_d = ST_DATA;
                end else if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                    if (PARITY != PAR_NONE) begin
                        state_d = ST_PARITY;
                        ser_d   = par_q;
                    end else begin
                        state_d = ST_STOP;
                        ser_d   = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    data_d    = data_q >> 1;
                    ser_d     = data_q[1];
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    ser_d   = 1'b1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                ser_d = 1'b1;
                if (!tick) begin
                    state_d = ST_STOP;
                end else if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                    state_d = ST_IDLE;
                    act_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ser_d   = 1'b1;
                act_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            bit_cnt_q  <= 4'd0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            ser_q      <= 1'b1;
            act_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            ser_q      <= ser_d;
            act_q      <= act_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- CLKS_PER_BIT, 217, clock cycles per serial bit; legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all logic is on its rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- tx_dv, in, 1, data valid; requests transmission of tx_data.
- tx_data, in, DATA_BITS, word to send.
- tx_ready, out, 1, high when a tx_dv will be accepted.
- tx_serial, out, 1, serial line; idles high.
- tx_active, out, 1, high while a frame is on the line.
- tx_done, out, 1, one-cycle pulse at frame completion.

Function
REQ-003 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-004 tx_ready SHALL equal (state == IDLE) combinationally; every other output SHALL be registered.
REQ-005 In IDLE with tx_dv=1 at edge k, the block SHALL capture tx_data, drive tx_serial=0 and tx_active=1 from cycle k+1, and enter START.
REQ-006 tx_dv SHALL be ignored in all states other than IDLE; there is no queue and no error flag.
REQ-007 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a counter of width $clog2(CLKS_PER_BIT) that clears at every bit boundary.
REQ-008 Data SHALL be sent LSB first from the captured copy; tx_data changes after acceptance SHALL have no effect.
REQ-009 PARITY SHALL be entered only when PARITY != 0.
- Even mode: the parity bit is ^data.
- Odd mode: the parity bit is ~^data.
REQ-010 STOP SHALL drive tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-011 A frame SHALL occupy CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
REQ-012 On the cycle following the last stop cycle, the FSM SHALL enter IDLE, pulse tx_done for 1 cycle and drop tx_active.
REQ-013 With tx_dv held high, the next frame's start bit SHALL begin exactly 1 idle-high cycle after the previous stop period ends.
REQ-014 In IDLE, tx_serial SHALL be 1.
REQ-015 An illegal parameter SHALL trigger an elaboration-time error.

Reset
REQ-016 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, tx_serial=1, tx_active=0, tx_done=0, counters=0 and data register=0, including mid-frame; the aborted frame SHALL NOT be resumed.
REQ-017 After rst_n deasserts, the first tx_dv SHALL be accepted on the first clk edge.

Structure
REQ-018 A shared package uart_pkg SHALL hold:
- the FSM state typedef;
- parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
- the elaboration-time parameter check.
REQ-019 Bit timing SHALL live in one sub-module, uart_bit_timer (parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output tick on the last cycle of a bit), reusable by the RX side.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-020 Bench SHALL cover these directed scenarios:
- 8N1, tx_data=0xA5 -> tx_serial 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; tx_done 1 cycle, 40 cycles after the start bit begins.
- PARITY=1, tx_data=0x07 -> parity bit 1; PARITY=2, tx_data=0x03 -> parity bit 1; frame is 44 cycles.
- tx_dv pulsed mid-DATA with 0xFF during an 0x00 frame -> first frame unchanged, no second frame, tx_ready=0 throughout.
- tx_dv held high with 0x55 then 0xAA -> two frames separated by exactly 1 high cycle; two tx_done pulses.
- rst_n low during bit 3 -> tx_serial=1 and tx_active=0 before the next clk edge; the next tx_dv starts a clean frame.
- DATA_BITS=5, STOP_BITS=2, tx_data=0x1F -> 0,1,1,1,1,1,1,1 with a 32-cycle frame.
